// File: rtl/regfile_param_if.sv
// Bus between decode/writeback and the register file: write port, dual read
// port, bulk-clear request and status.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              rvalid;
  logic              clr_req;
  logic              busy;

  modport master (
    output we, waddr, wdata, re, raddr1, raddr2, clr_req,
    input  rdata1, rdata2, rvalid, busy
  );

  modport slave (
    input  we, waddr, wdata, re, raddr1, raddr2, clr_req,
    output rdata1, rdata2, rvalid, busy
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered write-first read
// ports, optional hardwired zero entry and a one-entry-per-cycle bulk clear.
module regfile_param #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 5,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(8),
  parameter int                ZERO_REG  = 1
) (
  input logic            clk,
  input logic            rst_n,
  regfile_param_if.slave bus
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] CLEAR    = 1'b1;
  localparam bit         HAS_ZERO = (ZERO_REG != 0);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clrIdx;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] clrVal;
  logic [DATA_W-1:0] rdNext1;
  logic [DATA_W-1:0] rdNext2;
  logic [DATA_W-1:0] rdata1Q;
  logic [DATA_W-1:0] rdata2Q;
  logic              rvalidQ;
  logic              idle;
  logic              writeOk;

  assign idle    = (state == IDLE);
  assign writeOk = idle && bus.we && !(HAS_ZERO && (bus.waddr == '0));
  assign clrVal  = (HAS_ZERO && (clrIdx == '0)) ? '0 : RESET_VAL;

  // The sweep ends on the edge that writes the last index; clrIdx wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      clrIdx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state  <= CLEAR;
            clrIdx <= '0;
          end
        end
        CLEAR: begin
          clrIdx <= clrIdx + ADDR_W'(1);
          if (&clrIdx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (HAS_ZERO && (i == 0)) ? '0 : RESET_VAL;
      end
    end else if (state == CLEAR) begin
      regs[clrIdx] <= clrVal;
    end else if (writeOk) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Zero-entry rule is applied last so a suppressed write can never bypass.
  always_comb begin
    rdNext1 = regs[bus.raddr1];
    rdNext2 = regs[bus.raddr2];
    if (writeOk && (bus.waddr == bus.raddr1)) rdNext1 = bus.wdata;
    if (writeOk && (bus.waddr == bus.raddr2)) rdNext2 = bus.wdata;
    if (HAS_ZERO && (bus.raddr1 == '0)) rdNext1 = '0;
    if (HAS_ZERO && (bus.raddr2 == '0)) rdNext2 = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1Q <= '0;
      rdata2Q <= '0;
      rvalidQ <= 1'b0;
    end else if (idle && bus.re) begin
      rdata1Q <= rdNext1;
      rdata2Q <= rdNext2;
      rvalidQ <= 1'b1;
    end else begin
      rvalidQ <= 1'b0;
    end
  end

  assign bus.rdata1 = rdata1Q;
  assign bus.rdata2 = rdata2Q;
  assign bus.rvalid = rvalidQ;
  assign bus.busy   = (state == CLEAR);
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a default instance and a 16-bit/8-entry instance
// without a zero register, each checked every cycle against an array model.
module tb_regfile_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ifA ();
  regfile_param_if #(.DATA_W(16), .ADDR_W(3)) ifB ();

  regfile_param dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifA)
  );

  regfile_param #(
    .DATA_W(16), .ADDR_W(3), .RESET_VAL(16'hA5), .ZERO_REG(0)
  ) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model A: 32 x 32-bit, entry 0 reads 0, reset value 8; a clear is a countdown.
  logic [31:0] memA [32];
  logic [31:0] expA1, expA2;
  logic        expAV;
  int          clearLeftA;

  function automatic logic [31:0] readA(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (ifA.we && ifA.waddr == a) return ifA.wdata;
    return memA[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) memA[i] <= (i == 0) ? 32'd0 : 32'd8;
      expA1 <= '0;
      expA2 <= '0;
      expAV <= 1'b0;
      clearLeftA <= 0;
    end else if (clearLeftA > 0) begin
      memA[32 - clearLeftA] <= (clearLeftA == 32) ? 32'd0 : 32'd8;
      clearLeftA <= clearLeftA - 1;
      expAV <= 1'b0;
    end else begin
      if (ifA.re) begin
        expA1 <= readA(ifA.raddr1);
        expA2 <= readA(ifA.raddr2);
      end
      expAV <= ifA.re;
      if (ifA.we && ifA.waddr != 5'd0) memA[ifA.waddr] <= ifA.wdata;
      if (ifA.clr_req) clearLeftA <= 32;
    end
  end

  // Model B: 8 x 16-bit, every entry ordinary, reset value 0xA5.
  logic [15:0] memB [8];
  logic [15:0] expB1, expB2;
  logic        expBV;
  int          clearLeftB;

  function automatic logic [15:0] readB(input logic [2:0] a);
    if (ifB.we && ifB.waddr == a) return ifB.wdata;
    return memB[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) memB[i] <= 16'hA5;
      expB1 <= '0;
      expB2 <= '0;
      expBV <= 1'b0;
      clearLeftB <= 0;
    end else if (clearLeftB > 0) begin
      memB[8 - clearLeftB] <= 16'hA5;
      clearLeftB <= clearLeftB - 1;
      expBV <= 1'b0;
    end else begin
      if (ifB.re) begin
        expB1 <= readB(ifB.raddr1);
        expB2 <= readB(ifB.raddr2);
      end
      expBV <= ifB.re;
      if (ifB.we) memB[ifB.waddr] <= ifB.wdata;
      if (ifB.clr_req) clearLeftB <= 8;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("A.rdata1", ifA.rdata1, expA1);
      checkOutput("A.rdata2", ifA.rdata2, expA2);
      checkOutput("A.rvalid", 32'(ifA.rvalid), 32'(expAV));
      checkOutput("A.busy", 32'(ifA.busy), 32'(clearLeftA > 0));
      checkOutput("B.rdata1", 32'(ifB.rdata1), 32'(expB1));
      checkOutput("B.rdata2", 32'(ifB.rdata2), 32'(expB2));
      checkOutput("B.rvalid", 32'(ifB.rvalid), 32'(expBV));
      checkOutput("B.busy", 32'(ifB.busy), 32'(clearLeftB > 0));
    end
  end

  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic r, input logic [4:0] a1, input logic [4:0] a2,
                               input logic c);
    ifA.we = w; ifA.waddr = wa; ifA.wdata = wd;
    ifA.re = r; ifA.raddr1 = a1; ifA.raddr2 = a2; ifA.clr_req = c;
    @(negedge clk);
  endtask

  task automatic applyStimulusB(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                                input logic r, input logic [2:0] a1, input logic [2:0] a2,
                                input logic c);
    ifB.we = w; ifB.waddr = wa; ifB.wdata = wd;
    ifB.re = r; ifB.raddr1 = a1; ifB.raddr2 = a2; ifB.clr_req = c;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyCnt;
    ifA.we = 0; ifA.waddr = 0; ifA.wdata = 0; ifA.re = 0;
    ifA.raddr1 = 0; ifA.raddr2 = 0; ifA.clr_req = 0;
    ifB.we = 0; ifB.waddr = 0; ifB.wdata = 0; ifB.re = 0;
    ifB.raddr1 = 0; ifB.raddr2 = 0; ifB.clr_req = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("lit.resetRvalid", 32'(ifA.rvalid), 32'd0);
    checkOutput("lit.resetBusy", 32'(ifA.busy), 32'd0);

    applyStimulus(0, 0, 0, 1, 5'd3, 5'd0, 0);
    checkOutput("lit.read3", ifA.rdata1, 32'd8);
    checkOutput("lit.read0", ifA.rdata2, 32'd0);
    checkOutput("lit.rvalid", 32'(ifA.rvalid), 32'd1);

    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd5, 5'd3, 0);
    checkOutput("lit.writeRead5", ifA.rdata1, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("lit.holdRdata1", ifA.rdata1, 32'hDEADBEEF);
    checkOutput("lit.rvalidLow", 32'(ifA.rvalid), 32'd0);

    applyStimulus(1, 5'd7, 32'h1234, 1, 5'd5, 5'd7, 0);
    checkOutput("lit.bypass7", ifA.rdata2, 32'h1234);
    applyStimulus(1, 5'd0, 32'h55, 1, 5'd0, 5'd0, 0);
    checkOutput("lit.zeroBypass", ifA.rdata1, 32'd0);
    applyStimulus(0, 0, 0, 1, 5'd0, 5'd7, 0);
    checkOutput("lit.zeroRead", ifA.rdata1, 32'd0);

    for (int i = 1; i < 32; i++) applyStimulus(1, 5'(i), 32'(i), 0, 0, 0, 0);
    // Write, read and clear request on one edge: access completes, then sweep.
    applyStimulus(1, 5'd9, 32'h99, 1, 5'd9, 5'd4, 1);
    checkOutput("lit.clrEdgeBypass", ifA.rdata1, 32'h99);
    checkOutput("lit.clrEdgeRead4", ifA.rdata2, 32'd4);
    busyCnt = ifA.busy ? 1 : 0;
    for (int k = 0; k < 40 && ifA.busy; k++) begin
      applyStimulus(1, 5'(k), 32'hBAD, 1, 5'(k), 5'(k), 1);
      if (ifA.busy) busyCnt++;
    end
    checkOutput("lit.clearCyclesA", 32'(busyCnt), 32'd32);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(0, 0, 0, 1, 5'(a), 5'(31 - a), 0);
      if (a == 0) begin
        checkOutput("lit.postClr0", ifA.rdata1, 32'd0);
        checkOutput("lit.postClrRvalid", 32'(ifA.rvalid), 32'd1);
      end
      if (a == 9) checkOutput("lit.postClr9", ifA.rdata1, 32'd8);
    end

    applyStimulus(1, 5'd2, 32'h22, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd2, 5'd5, 1);
    checkOutput("lit.preRst2", ifA.rdata1, 32'h22);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (9) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("lit.rstBusy", 32'(ifA.busy), 32'd0);
    checkOutput("lit.rstRvalid", 32'(ifA.rvalid), 32'd0);
    checkOutput("lit.rstRdata1", ifA.rdata1, 32'd0);
    checkOutput("lit.rstRdata2", ifA.rdata2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      applyStimulus(0, 0, 0, 1, 5'(a), 5'(31 - a), 0);
      if (a == 2) checkOutput("lit.afterRst2", ifA.rdata1, 32'd8);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    applyStimulusB(0, 0, 0, 1, 3'd0, 3'd6, 0);
    checkOutput("lit.B.reset0", 32'(ifB.rdata1), 32'hA5);
    applyStimulusB(1, 3'd0, 16'h1357, 0, 0, 0, 0);
    applyStimulusB(0, 0, 0, 1, 3'd0, 3'd1, 0);
    checkOutput("lit.B.write0", 32'(ifB.rdata1), 32'h1357);
    checkOutput("lit.B.read1", 32'(ifB.rdata2), 32'hA5);
    applyStimulusB(1, 3'd0, 16'h2468, 1, 3'd0, 3'd0, 0);
    checkOutput("lit.B.bypass0", 32'(ifB.rdata2), 32'h2468);
    applyStimulusB(0, 0, 0, 0, 0, 0, 1);
    busyCnt = ifB.busy ? 1 : 0;
    for (int k = 0; k < 20 && ifB.busy; k++) begin
      applyStimulusB(1, 3'(k), 16'hBEEF, 1, 3'(k), 3'(k), 0);
      if (ifB.busy) busyCnt++;
    end
    checkOutput("lit.B.clearCycles", 32'(busyCnt), 32'd8);
    applyStimulusB(0, 0, 0, 1, 3'd0, 3'd7, 0);
    checkOutput("lit.B.postClr0", 32'(ifB.rdata1), 32'hA5);
    applyStimulusB(0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
